// File: rtl/corr_packet_decoder.sv
// corr_packet_decoder: reassembles one ASCII-hex correlator packet.
// Define CORR_PACKET_DECODER_HDR_CHECK_EN to reject mismatched headers.
module corr_packet_decoder #(
   parameter int RESOLUTION    = 24,
   parameter int PAYLOAD_WORDS = 4,
   parameter int NUM_INPUTS    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [15:0]           tick,
   output logic [3:0]            flags,
   output logic [7:0]            lag_cross,
   output logic [7:0]            lag_auto,
   output logic [11:0]           delay_size,
   output logic [7:0]            num_inputs,
   output logic [7:0]            resolution,
   output logic                  hdr_valid,
   output logic [RESOLUTION-1:0] word_data,
   output logic [15:0]           word_index,
   output logic                  word_valid,
   output logic [63:0]           timestamp,
   output logic                  pkt_done,
   output logic                  pkt_error
);

   localparam int         NPW       = RESOLUTION / 4;
   localparam logic [5:0] FLD_LAST  = 6'd15;
   localparam logic [5:0] WORD_LAST = 6'(NPW - 1);
   localparam logic [15:0] LAST_WORD = 16'(PAYLOAD_WORDS - 1);
   localparam logic [7:0] RES8      = 8'(RESOLUTION);
   localparam logic [7:0] NI8       = 8'(NUM_INPUTS - 1);
`ifdef CORR_PACKET_DECODER_HDR_CHECK_EN
   localparam logic       CHK_EN    = 1'b1;
`else
   localparam logic       CHK_EN    = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_HEADER,
      S_PAYLOAD,
      S_FOOTER,
      S_WAIT_EOP,
      S_DISCARD
   } state_t;

   state_t                  state;
   logic [5:0]              nib_cnt;
   logic [15:0]             word_cnt;
   logic [63:0]             hdr_sr;
   logic [63:0]             ts_sr;
   logic [RESOLUTION-1:0]   word_sr;
   logic                    chk_fail;

   logic                    is_hex;
   logic                    is_cr;
   logic                    is_ws;
   logic [3:0]              nib;
   logic [63:0]             hdr_next;
   logic [63:0]             ts_next;
   logic [RESOLUTION-1:0]   word_next;
   logic                    hdr_bad;

   always_comb begin
      is_hex = 1'b0;
      nib    = 4'd0;
      is_cr  = (rx_data == 8'h0D);
      is_ws  = (rx_data == 8'h0A) || (rx_data == 8'h20);
      unique case (1'b1)
         (rx_data >= 8'h30 && rx_data <= 8'h39): begin
            is_hex = 1'b1;
            nib    = rx_data[3:0];
         end
         (rx_data >= 8'h41 && rx_data <= 8'h46),
         (rx_data >= 8'h61 && rx_data <= 8'h66): begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
         end
         default: begin
            is_hex = 1'b0;
            nib    = 4'd0;
         end
      endcase
   end

   always_comb begin
      hdr_next  = {hdr_sr[59:0], nib};
      ts_next   = {ts_sr[59:0], nib};
      word_next = RESOLUTION'({word_sr, nib});
      hdr_bad   = CHK_EN &&
                  ((hdr_next[63:56] != RES8) ||
                   (hdr_next[55:48] != NI8));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_HEADER;
         nib_cnt    <= 6'd0;
         word_cnt   <= 16'd0;
         hdr_sr     <= 64'd0;
         ts_sr      <= 64'd0;
         word_sr    <= '0;
         chk_fail   <= 1'b0;
         tick       <= 16'd0;
         flags      <= 4'd0;
         lag_cross  <= 8'd0;
         lag_auto   <= 8'd0;
         delay_size <= 12'd0;
         num_inputs <= 8'd0;
         resolution <= 8'd0;
         hdr_valid  <= 1'b0;
         word_data  <= '0;
         word_index <= 16'd0;
         word_valid <= 1'b0;
         timestamp  <= 64'd0;
         pkt_done   <= 1'b0;
         pkt_error  <= 1'b0;
      end else begin
         hdr_valid  <= 1'b0;
         word_valid <= 1'b0;
         pkt_done   <= 1'b0;
         // a rejected header reports its error one cycle after hdr_valid
         pkt_error  <= chk_fail;
         chk_fail   <= 1'b0;
         if (rx_valid && !is_ws) begin
            if (state == S_DISCARD) begin
               if (is_cr)
                  state <= S_HEADER;
            end else if (is_cr) begin
               if (state == S_WAIT_EOP)
                  pkt_done  <= 1'b1;
               else
                  pkt_error <= 1'b1;
               state    <= S_HEADER;
               nib_cnt  <= 6'd0;
               word_cnt <= 16'd0;
            end else if (!is_hex || state == S_WAIT_EOP) begin
               pkt_error <= 1'b1;
               state     <= S_DISCARD;
               nib_cnt   <= 6'd0;
               word_cnt  <= 16'd0;
            end else begin
               unique case (state)
                  S_HEADER: begin
                     hdr_sr <= hdr_next;
                     if (nib_cnt == FLD_LAST) begin
                        nib_cnt    <= 6'd0;
                        hdr_valid  <= 1'b1;
                        resolution <= hdr_next[63:56];
                        num_inputs <= hdr_next[55:48];
                        delay_size <= hdr_next[47:36];
                        lag_auto   <= hdr_next[35:28];
                        lag_cross  <= hdr_next[27:20];
                        flags      <= hdr_next[19:16];
                        tick       <= hdr_next[15:0];
                        if (hdr_bad) begin
                           chk_fail <= 1'b1;
                           state    <= S_DISCARD;
                        end else if (PAYLOAD_WORDS == 0) begin
                           state <= S_FOOTER;
                        end else begin
                           state <= S_PAYLOAD;
                        end
                     end else begin
                        nib_cnt <= nib_cnt + 6'd1;
                     end
                  end
                  S_PAYLOAD: begin
                     word_sr <= word_next;
                     if (nib_cnt == WORD_LAST) begin
                        nib_cnt    <= 6'd0;
                        word_data  <= word_next;
                        word_index <= word_cnt;
                        word_valid <= 1'b1;
                        if (word_cnt == LAST_WORD) begin
                           word_cnt <= 16'd0;
                           state    <= S_FOOTER;
                        end else begin
                           word_cnt <= word_cnt + 16'd1;
                        end
                     end else begin
                        nib_cnt <= nib_cnt + 6'd1;
                     end
                  end
                  S_FOOTER: begin
                     ts_sr <= ts_next;
                     if (nib_cnt == FLD_LAST) begin
                        nib_cnt   <= 6'd0;
                        timestamp <= ts_next;
                        state     <= S_WAIT_EOP;
                     end else begin
                        nib_cnt <= nib_cnt + 6'd1;
                     end
                  end
                  default: begin
                     state <= S_DISCARD;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_corr_packet_decoder.sv
// tb_corr_packet_decoder: randomized packets, reference decoder model
// feeding an event scoreboard that a monitor checks against DUT pulses.
`timescale 1ns/1ps
module tb_corr_packet_decoder;

   localparam int RES   = 24;
   localparam int PW    = 4;
   localparam int NI    = 8;
   localparam int NPW   = RES / 4;
   localparam int TOTAL = 16 + PW * NPW + 16;
`ifdef CORR_PACKET_DECODER_HDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [7:0]     rx_data = 8'h00;
   logic           rx_valid = 1'b0;
   logic [15:0]    tick;
   logic [3:0]     flags;
   logic [7:0]     lag_cross;
   logic [7:0]     lag_auto;
   logic [11:0]    delay_size;
   logic [7:0]     num_inputs;
   logic [7:0]     resolution;
   logic           hdr_valid;
   logic [RES-1:0] word_data;
   logic [15:0]    word_index;
   logic           word_valid;
   logic [63:0]    timestamp;
   logic           pkt_done;
   logic           pkt_error;

   corr_packet_decoder #(
      .RESOLUTION(RES),
      .PAYLOAD_WORDS(PW),
      .NUM_INPUTS(NI)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tick(tick),
      .flags(flags),
      .lag_cross(lag_cross),
      .lag_auto(lag_auto),
      .delay_size(delay_size),
      .num_inputs(num_inputs),
      .resolution(resolution),
      .hdr_valid(hdr_valid),
      .word_data(word_data),
      .word_index(word_index),
      .word_valid(word_valid),
      .timestamp(timestamp),
      .pkt_done(pkt_done),
      .pkt_error(pkt_error)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {E_HDR, E_WORD, E_DONE, E_ERR} ek_t;
   typedef struct {
      ek_t         kind;
      longint      cyc;
      logic [63:0] val;
      int          idx;
   } ev_t;

   ev_t         exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          n_done = 0;
   int          n_err = 0;
   int          n_word = 0;

   // reference model: position of the nibble within the whole packet
   int          m_pos = 0;
   bit          m_bad = 1'b0;
   logic [63:0] m_acc = 64'd0;
   logic [63:0] m_ts = 64'd0;

   logic [7:0]     pkt[$];
   logic [RES-1:0] wbuf[PW];

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int hexval(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
      if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
      if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
      return -1;
   endfunction

   function automatic logic [7:0] hexchar(input logic [3:0] v,
                                          input bit lower);
      if (v < 4'd10) return 8'h30 + 8'(v);
      return (lower ? 8'h61 : 8'h41) + 8'(v) - 8'd10;
   endfunction

   task automatic push_ev(input ek_t k, input longint c,
                          input logic [63:0] v, input int idx);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.val  = v;
      e.idx  = idx;
      exp_q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b, input longint c);
      int v;
      v = hexval(b);
      if (b == 8'h0A || b == 8'h20) return;
      if (m_bad) begin
         if (b == 8'h0D) begin
            m_bad = 1'b0;
            m_pos = 0;
         end
         return;
      end
      if (b == 8'h0D) begin
         push_ev((m_pos == TOTAL) ? E_DONE : E_ERR, c, m_ts, 0);
         m_pos = 0;
         return;
      end
      if (v < 0 || m_pos == TOTAL) begin
         push_ev(E_ERR, c, 64'd0, 0);
         m_bad = 1'b1;
         m_pos = 0;
         return;
      end
      m_acc = (m_acc << 4) | 64'(v);
      m_pos++;
      if (m_pos == 16) begin
         push_ev(E_HDR, c, m_acc, 0);
         if (CHK && (m_acc[63:56] != 8'(RES) ||
                     int'(m_acc[55:48]) + 1 != NI)) begin
            push_ev(E_ERR, c + 1, 64'd0, 0);
            m_bad = 1'b1;
            m_pos = 0;
         end
      end else if (m_pos > 16 && m_pos <= 16 + PW * NPW &&
                   (m_pos - 16) % NPW == 0) begin
         push_ev(E_WORD, c, m_acc & ((64'd1 << RES) - 64'd1),
                 (m_pos - 16) / NPW - 1);
      end else if (m_pos == TOTAL) begin
         m_ts = m_acc;
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      model_byte(b, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
   endtask

   // casemode: 0 upper, 1 lower, 2 random per nibble
   task automatic add_field(input logic [63:0] val, input int nibs,
                            input int ws_pct, input int casemode);
      logic [3:0] n;
      bit         lo;
      for (int i = nibs - 1; i >= 0; i--) begin
         n  = val[i*4 +: 4];
         lo = (casemode == 2) ? bit'($urandom_range(0, 1))
                              : bit'(casemode);
         pkt.push_back(hexchar(n, lo));
         if (int'($urandom_range(0, 99)) < ws_pct)
            pkt.push_back($urandom_range(0, 1) ? 8'h20 : 8'h0A);
      end
   endtask

   task automatic build_pkt(input logic [63:0] hdr, input logic [63:0] ts,
                            input int ws_pct, input int casemode);
      add_field(hdr, 16, ws_pct, casemode);
      for (int w = 0; w < PW; w++)
         add_field(64'(wbuf[w]), NPW, ws_pct, casemode);
      add_field(ts, 16, ws_pct, casemode);
      pkt.push_back(8'h0D);
   endtask

   task automatic send_pkt(input int maxgap);
      foreach (pkt[i]) begin
         if (maxgap > 0) idle($urandom_range(0, maxgap));
         send(pkt[i]);
      end
      pkt.delete();
   endtask

   task automatic nominal_words();
      wbuf[0] = 24'h000001;
      wbuf[1] = 24'hABCDEF;
      wbuf[2] = 24'hFFFFFE;
      wbuf[3] = 24'h123456;
   endtask

   task automatic check_ev(input ek_t k);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected %s pulse at cycle %0d", k.name(), cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
         fails++;
         $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                  k.name(), cyc, e.kind.name(), e.cyc);
         return;
      end
      unique case (k)
         E_HDR: chk("header fields",
                    {resolution, num_inputs, delay_size, lag_auto,
                     lag_cross, flags, tick}, e.val);
         E_WORD: begin
            chk("word_data", 64'(word_data), e.val);
            chk("word_index", 64'(word_index), 64'(e.idx));
         end
         E_DONE: chk("timestamp at done", timestamp, e.val);
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (hdr_valid) check_ev(E_HDR);
         if (word_valid) begin
            n_word++;
            check_ev(E_WORD);
         end
         if (pkt_done) begin
            n_done++;
            check_ev(E_DONE);
         end
         if (pkt_error) begin
            n_err++;
            check_ev(E_ERR);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, " header"}, {resolution, num_inputs, delay_size, lag_auto,
                             lag_cross, flags, tick}, 64'd0);
      chk({tag, " word_data"}, 64'(word_data), 64'd0);
      chk({tag, " word_index"}, 64'(word_index), 64'd0);
      chk({tag, " timestamp"}, timestamp, 64'd0);
      chk({tag, " pulses"}, {60'd0, hdr_valid, word_valid, pkt_done,
                             pkt_error}, 64'd0);
   endtask

   initial begin
      int d0;
      int e0;
      int w0;
      logic [63:0] hdr;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      idle(2);

      // nominal packet
      d0 = n_done;
      e0 = n_err;
      nominal_words();
      add_field(64'h1807000000000064, 16, 0, 0);
      add_field(64'(wbuf[0]), NPW, 0, 0);
      add_field(64'(wbuf[1]), NPW, 0, 0);
      add_field(64'(wbuf[2]), NPW, 0, 1);
      add_field(64'(wbuf[3]), NPW, 0, 0);
      add_field(64'h3E80, 16, 0, 0);
      pkt.push_back(8'h0D);
      send_pkt(1);
      idle(3);
      chk("nominal tick", 64'(tick), 64'h0064);
      chk("nominal num_inputs", 64'(num_inputs), 64'd7);
      chk("nominal last word", 64'(word_data), 64'h123456);
      chk("nominal last index", 64'(word_index), 64'd3);
      chk("nominal timestamp", timestamp, 64'h3E80);
      chk("nominal done count", 64'(n_done - d0), 64'd1);
      chk("nominal error count", 64'(n_err - e0), 64'd0);

      // short packet: CR after two payload words
      e0 = n_err;
      w0 = n_word;
      add_field(64'h1807000000000064, 16, 0, 0);
      add_field(64'h111111, NPW, 0, 0);
      add_field(64'h222222, NPW, 0, 0);
      pkt.push_back(8'h0D);
      send_pkt(0);
      idle(3);
      chk("short error count", 64'(n_err - e0), 64'd1);
      chk("short word count", 64'(n_word - w0), 64'd2);
      build_pkt(64'h1807000000000064, 64'h3E80, 0, 2);
      send_pkt(0);
      idle(3);

      // illegal byte mid-header
      e0 = n_err;
      d0 = n_done;
      add_field(64'h1807, 4, 0, 0);
      pkt.push_back(8'h47);
      add_field(64'h12AB, 4, 0, 0);
      pkt.push_back(8'h0D);
      build_pkt(64'h1807000000000064, 64'h3E80, 0, 0);
      send_pkt(0);
      idle(3);
      chk("illegal error count", 64'(n_err - e0), 64'd1);
      chk("illegal then done", 64'(n_done - d0), 64'd1);

      // whitespace between every nibble, back-to-back strobes
      build_pkt(64'h1807000000000064, 64'h3E80, 100, 2);
      send_pkt(0);
      idle(3);
      chk("ws timestamp", timestamp, 64'h3E80);

      // reset after 10 payload nibbles
      build_pkt(64'h1807000000000064, 64'h3E80, 0, 0);
      for (int i = 0; i < 26; i++) send(pkt[i]);
      pkt.delete();
      idle(3);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      m_pos = 0;
      m_bad = 1'b0;
      m_ts  = 64'd0;
      check_zero("mid reset");
      reset = 1'b0;
      nominal_words();
      build_pkt(64'h1807000000000064, 64'h3E80, 0, 0);
      send_pkt(0);
      idle(3);

      // header resolution 0x10: rejected only when field checking is on
      w0 = n_word;
      build_pkt(64'h1007000000000064, 64'h55, 0, 0);
      send_pkt(0);
      idle(3);
      chk("bad-res words", 64'(n_word - w0), CHK ? 64'd0 : 64'(PW));
      nominal_words();
      build_pkt(64'h1807000000000064, 64'h3E80, 0, 0);
      send_pkt(0);
      idle(3);

      // randomized packets with occasional faults
      for (int p = 0; p < 40; p++) begin
         int r;
         int k;
         hdr = {$urandom, $urandom};
         if ($urandom_range(0, 7) != 0) hdr[63:48] = 16'h1807;
         for (int w = 0; w < PW; w++) wbuf[w] = RES'($urandom);
         build_pkt(hdr, {$urandom, $urandom},
                   $urandom_range(0, 30), 2);
         r = $urandom_range(0, 9);
         if (r == 0) begin
            k = $urandom_range(0, pkt.size() - 2);
            pkt = pkt[0:k];
            pkt.push_back(8'h0D);
         end else if (r == 1) begin
            k = $urandom_range(0, pkt.size() - 1);
            pkt.insert(k, 8'h5A);
         end else if (r == 2) begin
            pkt.insert(pkt.size() - 1, 8'h35);
         end
         send_pkt($urandom_range(0, 2));
      end

      idle(20);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
